// File: rtl/user_field_inserter.sv
// rtl/user_field_inserter.sv - frame counter field inserter for the TX beat stream
//
// Purpose: overwrites a window of the user-data region of each frame with the
// current frame counter (MSB digit first), passes every other beat through,
// with one cycle of latency on data, valid and user.
// Optional feature: define USER_FIELD_CHECKSUM_EN to append one beat carrying
// the XOR of all counter digits after the counter field.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_data      input beat (DW bits)
//   in_user      beat belongs to the user-data region
//   in_valid     beat valid; a frame is a contiguous in_valid-high run
//   cnt_en       allow counter increment at frame end
//   cnt_load     one-cycle counter preload request
//   cnt_load_val preload value (CNT_W bits)
//   out_data     output beat (DW bits)
//   out_valid    in_valid delayed one cycle
//   out_user     in_user delayed one cycle
//   frame_cnt    current counter value (CNT_W bits)

module user_field_inserter #(
   parameter int DW        = 4,
   parameter int CNT_W     = 16,
   parameter int FIELD_OFS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    in_data,
   input  logic             in_user,
   input  logic             in_valid,
   input  logic             cnt_en,
   input  logic             cnt_load,
   input  logic [CNT_W-1:0] cnt_load_val,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   output logic             out_user,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int N = CNT_W / DW;
`ifdef USER_FIELD_CHECKSUM_EN
   localparam int L = N + 1;
`else
   localparam int L = N;
`endif
   localparam int IDX_MAX = FIELD_OFS + L;
   localparam int IDX_W   = $clog2(IDX_MAX + 1);

   generate
      if ((CNT_W % DW) != 0 || CNT_W < DW) begin : g_bad_width
         $error("user_field_inserter: CNT_W must be a non-zero multiple of DW");
      end
   endgenerate

   logic [IDX_W-1:0] idx;
   logic             pend;
   logic [CNT_W-1:0] pend_val;
   logic [DW-1:0]    field_data;
   logic             frame_end;
   logic             idle;

   // The cycle after the last valid beat has been registered closes the frame.
   assign frame_end = out_valid & ~in_valid;
   assign idle      = ~in_valid & ~out_valid;

   always_comb begin
      field_data = in_data;
      if (in_valid && in_user) begin
         for (int p = 0; p < N; p++) begin
            if (idx == IDX_W'(FIELD_OFS + p))
               field_data = frame_cnt[(N-1-p)*DW +: DW];
         end
`ifdef USER_FIELD_CHECKSUM_EN
         if (idx == IDX_W'(FIELD_OFS + N)) begin
            field_data = '0;
            for (int k = 0; k < N; k++)
               field_data = field_data ^ frame_cnt[k*DW +: DW];
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_user  <= 1'b0;
         frame_cnt <= '0;
         idx       <= '0;
         pend      <= 1'b0;
         pend_val  <= '0;
      end else begin
         out_data  <= field_data;
         out_valid <= in_valid;
         out_user  <= in_user;

         // idx saturates once past the field so long user regions never wrap it.
         if (!in_user)
            idx <= '0;
         else if (in_valid && idx != IDX_W'(IDX_MAX))
            idx <= idx + IDX_W'(1);

         // The counter only moves while no frame is in flight, so every digit
         // of one frame is taken from the same value.
         if (frame_end) begin
            if (cnt_load)
               frame_cnt <= cnt_load_val;
            else if (pend)
               frame_cnt <= pend_val;
            else if (cnt_en)
               frame_cnt <= frame_cnt + CNT_W'(1);
            pend <= 1'b0;
         end else if (cnt_load) begin
            if (idle) begin
               frame_cnt <= cnt_load_val;
            end else begin
               pend     <= 1'b1;
               pend_val <= cnt_load_val;
            end
         end
      end
   end

endmodule
